// File: rtl/fle_cfg_pkg.sv
// fle_cfg_pkg: shared FSM state type and CRC-16-CCITT constants for the FLE config bank.
package fle_cfg_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/fle_cfg_crc16.sv
// fle_cfg_crc16: CRC-16-CCITT over LANES bits per step, lane 0 first.
module fle_cfg_crc16
    import fle_cfg_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [LANES-1:0] data_i,
    output logic [15:0]      crc_o
);
    logic [15:0] crc_q, crc_d;
    always_comb begin
        crc_d = crc_q;
        for (int l = 0; l < LANES; l++)
            crc_d = {crc_d[14:0], 1'b0} ^ ((crc_d[15] ^ data_i[l]) ? CRC_POLY : 16'h0000);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) crc_q <= CRC_INIT;
        else if (clr_i) crc_q <= CRC_INIT;
        else if (en_i) crc_q <= crc_d;
    end
    assign crc_o = crc_q;
endmodule

// File: rtl/logical_tile_fle_cfg_bank.sv
// logical_tile_fle_cfg_bank: multi-lane config shift chain with atomic commit to mem_out.
// Optional CRC-16 load check compiled in with CCFF_CRC_EN.
module logical_tile_fle_cfg_bank
    import fle_cfg_pkg::*;
#(
    parameter int CFG_BITS = 32,
    parameter int LANES    = 1
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                test_enable,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [LANES-1:0]    ccff_head,
    input  logic                ccff_valid,
    output logic                ccff_ready,
    output logic [LANES-1:0]    ccff_tail,
    input  logic [15:0]         crc_exp,
    output logic [CFG_BITS-1:0] mem_out,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err
);
    localparam int D  = CFG_BITS / LANES;
    localparam int CW = $clog2(D + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CFG_BITS-1:0]   sr_q, sr_d, mem_q;
    logic                  start_ok, beat, last, crc_bad, in_commit;

    assign start_ok   = (state_q == IDLE) && cfg_start && !cfg_abort;
    assign ccff_ready = (state_q == SHIFT);
    assign beat       = ccff_ready && ccff_valid;
    assign last       = beat && (cnt_q == CW'(D - 1));
    assign cfg_busy   = (state_q != IDLE);
    assign in_commit  = (state_q == COMMIT) && !cfg_abort;
    assign cfg_done   = in_commit && !crc_bad && !test_enable;
    assign mem_out    = mem_q;

`ifdef CCFF_CRC_EN
    logic [15:0] crc, crc_exp_q;
    fle_cfg_crc16 #(.LANES(LANES)) u_crc (
        .clk_i  (prog_clk),
        .rst_ni (prog_reset_n),
        .clr_i  (start_ok),
        .en_i   (beat),
        .data_i (ccff_head),
        .crc_o  (crc)
    );
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) crc_exp_q <= 16'h0000;
        else if (start_ok) crc_exp_q <= crc_exp;
    end
    assign crc_bad = (crc != crc_exp_q);
    assign cfg_err = in_commit && crc_bad;
`else
    logic unused_crc_exp;
    assign unused_crc_exp = ^crc_exp;
    assign crc_bad = 1'b0;
    assign cfg_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: if (cfg_abort) state_d = IDLE;
            else if (beat) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? COMMIT : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Each lane shifts toward its top index, so the first bit of a lane ends at l*D+D-1.
    always_comb begin
        sr_d = sr_q;
        for (int l = 0; l < LANES; l++) begin
            sr_d[l*D] = ccff_head[l];
            for (int k = 1; k < D; k++) sr_d[l*D+k] = sr_q[l*D+k-1];
            ccff_tail[l] = sr_q[l*D+D-1];
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (beat) sr_q <= sr_d;
            if (cfg_done) mem_q <= sr_q;
        end
    end
endmodule

// File: tb/tb_logical_tile_fle_cfg_bank.sv
// tb_logical_tile_fle_cfg_bank: directed loads on a 1-lane and a 4-lane bank against a history-queue model.
module tb_logical_tile_fle_cfg_bank;
    logic        clk = 0, rst_n = 0, te = 0;
    logic [15:0] cexp = 0;
    logic [1:0]  vld = 0, sta = 0, abo = 0;
    logic [3:0]  hd [2];
    logic        rdy1, rdy4, busy1, busy4, done1, done4, err1, err4;
    logic [0:0]  tail1;
    logic [3:0]  tail4;
    logic [31:0] mem1, mem4;

    always #5 clk = ~clk;

    logical_tile_fle_cfg_bank #(.CFG_BITS(32), .LANES(1)) u1 (
        .prog_clk(clk), .prog_reset_n(rst_n), .test_enable(te), .cfg_start(sta[0]),
        .cfg_abort(abo[0]), .ccff_head(hd[0][0]), .ccff_valid(vld[0]), .ccff_ready(rdy1),
        .ccff_tail(tail1), .crc_exp(cexp), .mem_out(mem1), .cfg_busy(busy1),
        .cfg_done(done1), .cfg_err(err1));

    logical_tile_fle_cfg_bank #(.CFG_BITS(32), .LANES(4)) u4 (
        .prog_clk(clk), .prog_reset_n(rst_n), .test_enable(te), .cfg_start(sta[1]),
        .cfg_abort(abo[1]), .ccff_head(hd[1]), .ccff_valid(vld[1]), .ccff_ready(rdy4),
        .ccff_tail(tail4), .crc_exp(cexp), .mem_out(mem4), .cfg_busy(busy4),
        .cfg_done(done4), .cfg_err(err4));

    int          checks = 0, errors = 0;
    int          dcnt [2] = '{0, 0};
    int          ecnt [2] = '{0, 0};
    int          ph [2] = '{0, 0};
    int          nb [2] = '{0, 0};
    logic [3:0]  hist [2][$];
    logic [15:0] mcrc [2], mce [2];
    logic [31:0] emem [2];
    logic        last_done;
    logic [31:0] mem_at_commit;

    function automatic int lanes(int i); return i ? 4 : 1; endfunction
    function automatic int dep(int i); return i ? 8 : 32; endfunction

    function automatic logic [15:0] crc_upd(logic [15:0] c, logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // CRC of a word in the order its bits will be shifted in: beat by beat, lane 0 first.
    function automatic logic [15:0] crc_word(int i, logic [31:0] w);
        logic [15:0] c = 16'hFFFF;
        for (int j = 0; j < dep(i); j++)
            for (int l = 0; l < lanes(i); l++) c = crc_upd(c, w[l*dep(i)+dep(i)-1-j]);
        return c;
    endfunction

    function automatic logic crc_ok(int i);
`ifdef CCFF_CRC_EN
        return mcrc[i] == mce[i];
`else
        return 1'b1;
`endif
    endfunction

    // Bank contents are just the last D beats per lane, newest at the bottom of each slice.
    function automatic logic [31:0] word_of(int i);
        logic [31:0] w = '0;
        int sz = hist[i].size();
        for (int l = 0; l < lanes(i); l++)
            for (int k = 0; k < dep(i); k++)
                if (sz > k) w[l*dep(i)+k] = hist[i][sz-1-k][l];
        return w;
    endfunction

    function automatic logic tail_of(int i, int l);
        int sz = hist[i].size();
        return (sz >= dep(i)) ? hist[i][sz-dep(i)][l] : 1'b0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ph[i] = 0; nb[i] = 0; hist[i].delete(); emem[i] = '0; mcrc[i] = 16'hFFFF;
            end else if (ph[i] == 0) begin
                if (sta[i] && !abo[i]) begin
                    ph[i] = 1; nb[i] = 0; mcrc[i] = 16'hFFFF; mce[i] = cexp;
                end
            end else if (ph[i] == 1) begin
                if (vld[i]) begin
                    hist[i].push_back(hd[i]);
                    for (int l = 0; l < lanes(i); l++) mcrc[i] = crc_upd(mcrc[i], hd[i][l]);
                    nb[i]++;
                end
                if (abo[i]) ph[i] = 0;
                else if (nb[i] == dep(i)) ph[i] = 2;
            end else begin
                if (!abo[i] && !te && crc_ok(i)) emem[i] = word_of(i);
                ph[i] = 0;
            end
        end
    end

    initial forever begin
        logic [3:0] et;
        logic       xd, xe;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            et = '0;
            for (int l = 0; l < lanes(i); l++) et[l] = tail_of(i, l);
            xd = (ph[i] == 2) && !abo[i] && !te && crc_ok(i);
`ifdef CCFF_CRC_EN
            xe = (ph[i] == 2) && !abo[i] && !crc_ok(i);
`else
            xe = 1'b0;
`endif
            chk($sformatf("u%0d busy", i), {31'b0, i ? busy4 : busy1}, {31'b0, ph[i] != 0});
            chk($sformatf("u%0d ready", i), {31'b0, i ? rdy4 : rdy1}, {31'b0, ph[i] == 1});
            chk($sformatf("u%0d done", i), {31'b0, i ? done4 : done1}, {31'b0, xd});
            chk($sformatf("u%0d err", i), {31'b0, i ? err4 : err1}, {31'b0, xe});
            chk($sformatf("u%0d tail", i), {28'b0, i ? tail4 : {3'b0, tail1}}, {28'b0, et});
            chk($sformatf("u%0d mem", i), i ? mem4 : mem1, emem[i]);
            if (i ? done4 : done1) dcnt[i]++;
            if (i ? err4 : err1) ecnt[i]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int i, logic [31:0] w, int gap, int abort_at, logic tem, logic [15:0] ce);
        cexp = ce; sta[i] = 1; step(); sta[i] = 0;
        for (int j = 0; j < dep(i); j++) begin
            if (j == abort_at) begin
                abo[i] = 1; step(); abo[i] = 0;
                return;
            end
            repeat (gap) step();
            for (int l = 0; l < lanes(i); l++) hd[i][l] = w[l*dep(i)+dep(i)-1-j];
            vld[i] = 1; step(); vld[i] = 0;
        end
        te = tem;
        @(negedge clk);
        last_done = i ? done4 : done1;
        mem_at_commit = i ? mem4 : mem1;
        step(); te = 0; step();
    endtask

    initial begin
        int d0;
        hd[0] = '0; hd[1] = '0;
        repeat (3) step();
        chk("reset mem1", mem1, 32'h0);
        chk("reset busy4", {31'b0, busy4}, 32'h0);
        rst_n = 1; step();

        d0 = dcnt[0];
        load(0, 32'hA5A50F0F, 0, -1, 0, crc_word(0, 32'hA5A50F0F));
        chk("load1 mem", mem1, 32'hA5A50F0F);
        chk("load1 done on commit", {31'b0, last_done}, 32'h1);
        chk("load1 mem before commit", mem_at_commit, 32'h0);
        chk("load1 done count", dcnt[0] - d0, 1);
        chk("load1 tail", {31'b0, tail1}, 32'h1);

        load(1, 32'h5A81F03C, 0, -1, 0, crc_word(1, 32'h5A81F03C));
        chk("lanes4 mem", mem4, 32'h5A81F03C);
        chk("lanes4 tail", {28'b0, tail4}, 32'h6);

        d0 = dcnt[0];
        load(0, 32'h12345678, 3, -1, 0, crc_word(0, 32'h12345678));
        chk("backpressure mem", mem1, 32'h12345678);
        chk("backpressure done count", dcnt[0] - d0, 1);

        d0 = dcnt[0];
        load(0, 32'hFFFFFFFF, 0, 17, 0, crc_word(0, 32'hFFFFFFFF));
        step();
        chk("abort mem held", mem1, 32'h12345678);
        chk("abort no done", dcnt[0] - d0, 0);
        chk("abort idle", {31'b0, busy1}, 32'h0);

        d0 = dcnt[0];
        load(0, 32'hDEADBEEF, 0, -1, 1, crc_word(0, 32'hDEADBEEF));
        chk("test_enable mem held", mem1, 32'h12345678);
        chk("test_enable no done", {31'b0, last_done}, 32'h0);
        chk("test_enable done count", dcnt[0] - d0, 0);

        sta[0] = 1; abo[0] = 1; step(); sta[0] = 0; abo[0] = 0;
        chk("start+abort idle", {31'b0, busy1}, 32'h0);

`ifdef CCFF_CRC_EN
        d0 = dcnt[0];
        load(0, 32'hC0FFEE11, 0, -1, 0, crc_word(0, 32'hC0FFEE11));
        chk("crc good mem", mem1, 32'hC0FFEE11);
        chk("crc good done", dcnt[0] - d0, 1);
        d0 = ecnt[0];
        load(0, 32'h0BADF00D, 0, -1, 0, crc_word(0, 32'h0BADF00D) ^ 16'h1);
        chk("crc bad mem held", mem1, 32'hC0FFEE11);
        chk("crc bad err", ecnt[0] - d0, 1);
`endif

        sta[0] = 1; step(); sta[0] = 0;
        for (int j = 0; j < 10; j++) begin
            hd[0][0] = j[0]; vld[0] = 1; step();
        end
        #2 rst_n = 0;
        #1;
        chk("async reset mem", mem1, 32'h0);
        chk("async reset busy", {31'b0, busy1}, 32'h0);
        chk("async reset ready", {31'b0, rdy1}, 32'h0);
        chk("async reset done/err", {30'b0, done1, err1}, 32'h0);
        chk("async reset tail", {31'b0, tail1}, 32'h0);
        vld[0] = 0;
        step(); step();
        rst_n = 1;
        step(); step();
        chk("post reset mem", mem1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logical_tile_fle_cfg_bank.md
LOGICAL_TILE_FLE_CFG_BANK -- requirements
Module: logical_tile_fle_cfg_bank

Interface
REQ-001 Parameter CFG_BITS, default 32: total configuration bits held by the bank; SHALL be divisible by LANES.
REQ-002 Parameter LANES, default 1: number of parallel configuration-chain lanes shifted per beat; depth per lane D = CFG_BITS/LANES.
REQ-003 Port prog_clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 Port prog_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port test_enable, input, 1: freezes commit; mem_out holds while high.
REQ-006 Port cfg_start, input, 1: begins a load; sampled only in IDLE.
REQ-007 Port cfg_abort, input, 1: cancels a load in progress.
REQ-008 Port ccff_head, input, LANES: configuration data, one bit per lane per beat.
REQ-009 Port ccff_valid, input, 1: ccff_head is valid this cycle.
REQ-010 Port ccff_ready, output, 1: bank accepts a beat this cycle.
REQ-011 Port ccff_tail, output, LANES: last shift stage of each lane, for daisy-chaining.
REQ-012 Port crc_exp, input, 16: expected CRC, sampled on the accepted cfg_start.
REQ-013 Port mem_out, output, CFG_BITS: committed configuration driving the fabric.
REQ-014 Port cfg_busy, output, 1: high in SHIFT and COMMIT.
REQ-015 Port cfg_done, output, 1: one-cycle pulse on successful commit.
REQ-016 Port cfg_err, output, 1: one-cycle pulse on CRC mismatch.

Function
REQ-017 FSM states: IDLE, SHIFT and COMMIT; IDLE->SHIFT on cfg_start; SHIFT->COMMIT after the D-th accepted beat; COMMIT->IDLE after one cycle.
REQ-018 ccff_ready SHALL be high only in SHIFT; a beat is accepted when ccff_valid && ccff_ready.
REQ-019 On an accepted beat, for each lane l: sr[l*D] <= ccff_head[l] and sr[l*D+k] <= sr[l*D+k-1] for k = 1..D-1; ccff_tail[l] = sr[l*D+D-1].
REQ-020 The first accepted bit of lane l SHALL end at index l*D+D-1, so MSB-first shifting reproduces the word.
REQ-021 A beat counter of width clog2(D+1) SHALL clear on entry to SHIFT and SHALL NOT wrap.
REQ-022 In COMMIT with test_enable low and no CRC error, mem_out <= sr; cfg_done SHALL pulse in that same cycle, so mem_out is updated one cycle after the last beat.
REQ-023 In COMMIT with test_enable high, mem_out SHALL be held and cfg_done SHALL NOT pulse; cfg_err behaves per REQ-030.
REQ-024 cfg_abort in SHIFT or COMMIT SHALL force IDLE next cycle, with no commit and no done/err pulse; cfg_abort has priority over the last beat.
REQ-025 cfg_start outside IDLE SHALL be ignored; cfg_start and cfg_abort together in IDLE SHALL stay IDLE.
REQ-026 mem_out SHALL change only in COMMIT, so the fabric never sees a partial configuration.

Reset
REQ-027 Asserting prog_reset_n low SHALL immediately set state=IDLE, counter=0, sr=0, mem_out=0, CRC=0xFFFF, and cfg_busy, cfg_done, cfg_err and ccff_ready to 0.
REQ-028 Reset during SHIFT SHALL discard the partial load; no pulse SHALL be generated.

Configuration
REQ-029 Macro CCFF_CRC_EN SHALL compile in a CRC-16-CCITT checker (poly 0x1021, init 0xFFFF, shift-in order lane 0..LANES-1 each beat) over accepted bits.
REQ-030 With CCFF_CRC_EN defined, a COMMIT whose CRC differs from crc_exp SHALL skip the update, pulse cfg_err, hold mem_out and return to IDLE.
REQ-031 Without CCFF_CRC_EN, the checker logic SHALL be absent, crc_exp SHALL be ignored and cfg_err SHALL be constant 0.

Structure
REQ-032 A shared package fle_cfg_pkg SHALL hold the FSM state enum, CRC_POLY = 16'h1021 and CRC_INIT = 16'hFFFF.
REQ-033 One sub-module, fle_cfg_crc16 (LANES bits per step, with clear and enable inputs), SHALL be instantiated only under CCFF_CRC_EN.

Verification
REQ-034 Load test (CFG_BITS=32, LANES=1): shift 0xA5A50F0F MSB-first over 32 beats -> mem_out=0xA5A50F0F and cfg_done pulses one cycle after the last beat.
REQ-035 Multi-lane load (LANES=4): 8 beats -> each lane's slice matches its bit stream and ccff_tail[l] equals the bit entered 8 beats earlier.
REQ-036 Abort and reset: cfg_abort at beat 17 -> IDLE, mem_out unchanged, no pulse; prog_reset_n low at beat 10 -> all outputs 0 asynchronously.
REQ-037 Backpressure: ccff_valid gaps of 3 cycles -> counter advances only on accepted beats and the final mem_out is correct.
REQ-038 CRC (CCFF_CRC_EN): correct crc_exp -> cfg_done; crc_exp ^ 1 -> cfg_err, mem_out held.
REQ-039 test_enable high during COMMIT -> mem_out held, no cfg_done.
